// File: rtl/button_debouncer.sv
// Input conditioning for a raw asynchronous level: two-flop synchroniser followed
// by a confirm/stable FSM that only accepts a new level after STABLE_CYCLES samples.
module button_debouncer #(
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned CNT_W         = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_in,
  output logic level_out,
  output logic rise_pulse,
  output logic fall_pulse
);

  typedef enum logic [1:0] {
    STABLE_LO  = 2'd0,
    CONFIRM_HI = 2'd1,
    STABLE_HI  = 2'd2,
    CONFIRM_LO = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic         sync1;
  logic         sync_q;
  logic [CNT_W-1:0] cnt;
  state_t       state;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1  <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      sync1  <= raw_in;
      sync_q <= sync1;
    end
  end

  // Pulses default low every edge so they can only ever last one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= STABLE_LO;
      cnt        <= '0;
      level_out  <= 1'b0;
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
    end else begin
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
      case (state)
        STABLE_LO: begin
          if (sync_q) begin
            state <= CONFIRM_HI;
            cnt   <= CNT_W'(1);
          end
        end
        CONFIRM_HI: begin
          if (!sync_q) begin
            state <= STABLE_LO;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state      <= STABLE_HI;
            level_out  <= 1'b1;
            rise_pulse <= 1'b1;
            cnt        <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        STABLE_HI: begin
          if (!sync_q) begin
            state <= CONFIRM_LO;
            cnt   <= CNT_W'(1);
          end
        end
        CONFIRM_LO: begin
          if (sync_q) begin
            state <= STABLE_HI;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state      <= STABLE_LO;
            level_out  <= 1'b0;
            fall_pulse <= 1'b1;
            cnt        <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          state     <= STABLE_LO;
          cnt       <= '0;
          level_out <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_button_debouncer.sv
// Bench for button_debouncer: directed scenarios plus random bounce traffic,
// compared every cycle against a run-length model of the debounce rule.
module tb_button_debouncer;

  localparam int N = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic raw_in = 1'b0;
  logic level_out, rise_pulse, fall_pulse;

  button_debouncer #(.STABLE_CYCLES(N), .CNT_W(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .raw_in    (raw_in),
    .level_out (level_out),
    .rise_pulse(rise_pulse),
    .fall_pulse(fall_pulse)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int rises = 0;
  int falls = 0;

  // Model: a new level is accepted once N consecutive synchronised samples
  // (raw_in delayed two edges) differ from the current level.
  bit m_p0, m_p1, m_level, m_rise, m_fall;
  int m_run;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge();
    if (rst) begin
      m_p0 = 0; m_p1 = 0; m_level = 0; m_run = 0; m_rise = 0; m_fall = 0;
    end else begin
      m_rise = 0; m_fall = 0;
      if (m_p1 != m_level) begin
        m_run++;
        if (m_run == N) begin
          m_level = m_p1;
          m_rise  = m_p1;
          m_fall  = !m_p1;
          m_run   = 0;
        end
      end else begin
        m_run = 0;
      end
      m_p1 = m_p0;
      m_p0 = raw_in;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check("level", level_out, m_level);
    check("rise", rise_pulse, m_rise);
    check("fall", fall_pulse, m_fall);
    check("both_pulses", rise_pulse & fall_pulse, 0);
    if (rise_pulse) rises++;
    if (fall_pulse) falls++;
  endtask

  task automatic run(input bit r, input bit v, input int n);
    rst = r;
    raw_in = v;
    repeat (n) tick();
  endtask

  // Hold raw_in and report the edge (1-based) at which level_out becomes want.
  task automatic latency(input bit v, input bit want, input int budget, output int edge_at);
    edge_at = 0;
    rst = 0;
    raw_in = v;
    for (int e = 1; e <= budget; e++) begin
      tick();
      if (edge_at == 0 && level_out == want) edge_at = e;
    end
  endtask

  initial begin
    int lat, r0, f0;

    // 1. reset
    run(1, 0, 2);
    check("reset_level", level_out, 0);
    check("reset_rise", rise_pulse, 0);
    check("reset_fall", fall_pulse, 0);

    // 2. clean rise
    r0 = rises; f0 = falls;
    latency(1, 1, 10, lat);
    check("rise_latency", lat, 6);
    check("rise_count", rises - r0, 1);
    check("rise_no_fall", falls - f0, 0);

    // 3. short low excursion from high
    r0 = rises; f0 = falls;
    run(0, 0, 3);
    run(0, 1, 8);
    check("glitch_level", level_out, 1);
    check("glitch_rises", rises - r0, 0);
    check("glitch_falls", falls - f0, 0);

    // 4. bounce then hold high
    run(0, 0, 10);
    r0 = rises;
    run(0, 1, 1); run(0, 0, 1); run(0, 1, 1); run(0, 0, 1);
    latency(1, 1, 10, lat);
    check("bounce_latency", lat, 6);
    check("bounce_rises", rises - r0, 1);

    // 5. reset mid-confirm
    run(0, 0, 10);
    r0 = rises;
    run(0, 1, 4);
    run(1, 1, 1);
    check("midrst_level", level_out, 0);
    check("midrst_rise", rise_pulse, 0);
    latency(1, 1, 10, lat);
    check("midrst_latency", lat, 6);
    check("midrst_rises", rises - r0, 1);

    // 6. clean fall from stable high
    r0 = rises; f0 = falls;
    latency(0, 0, 10, lat);
    check("fall_latency", lat, 6);
    check("fall_count", falls - f0, 1);
    check("fall_no_rise", rises - r0, 0);

    // random bounce traffic with occasional resets
    for (int i = 0; i < 400; i++) begin
      bit v;
      int len;
      v = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 8);
      if ($urandom_range(0, 40) == 0) run(1, v, 1);
      run(0, v, len);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
